// File: rtl/dram_access_controller_if.sv
// Bus bundle between the DRAM access controller and its clients (UART, processor, DRAM).
// master = the controller itself, slave = the surrounding clients and memory.
interface dram_access_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_wren;
    logic              proc_done;
    logic              enable_processor;
    logic [DATA_W-1:0] proc_rdata;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic              dram_wren;
    logic [DATA_W-1:0] dram_q;
    logic [1:0]        state;

    modport master (
        input  rx_valid, rx_data, proc_addr, proc_wdata, proc_wren, proc_done, tx_busy, dram_q,
        output enable_processor, proc_rdata, tx_start, tx_data, dram_addr, dram_wdata, dram_wren, state
    );

    modport slave (
        output rx_valid, rx_data, proc_addr, proc_wdata, proc_wren, proc_done, tx_busy, dram_q,
        input  enable_processor, proc_rdata, tx_start, tx_data, dram_addr, dram_wdata, dram_wren, state
    );
endinterface

// File: rtl/dram_access_controller.sv
// Time-shares one DRAM port between UART load, processor execution and UART dump,
// sequencing LOAD -> RUN -> DUMP -> DONE.
module dram_access_controller #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int LOAD_LEN  = 256,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 256,
    parameter int RD_LAT    = 1
) (
    input logic clk_in,
    input logic rst,
    dram_access_controller_if.master bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        D_RD, D_WAIT, D_SEND, D_HOLD1, D_HOLD
    } dump_t;

    phase_t            phase;
    dump_t             dsub;
    logic [PTR_W-1:0]  load_ptr;
    logic [PTR_W-1:0]  dump_ptr;
    logic [CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wren_r;
    logic              tx_start_r;
    logic [DATA_W-1:0] tx_data_r;
    logic [ADDR_W-1:0] dump_addr;

    // Address sum is truncated to ADDR_W so a base near the top wraps to 0.
    assign dump_addr = ADDR_W'(DUMP_BASE) + dump_ptr[ADDR_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            phase      <= S_LOAD;
            dsub       <= D_RD;
            load_ptr   <= '0;
            dump_ptr   <= '0;
            lat_cnt    <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wren_r     <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
        end else begin
            wren_r     <= 1'b0;
            tx_start_r <= 1'b0;
            case (phase)
                S_LOAD: begin
                    // Leave LOAD only after the final byte's write cycle has been presented.
                    if (wren_r && load_ptr == PTR_W'(LOAD_LEN)) begin
                        phase <= S_RUN;
                    end else if (bus.rx_valid && load_ptr < PTR_W'(LOAD_LEN)) begin
                        addr_r   <= load_ptr[ADDR_W-1:0];
                        wdata_r  <= bus.rx_data;
                        wren_r   <= 1'b1;
                        load_ptr <= load_ptr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.proc_done) begin
                        phase <= S_DUMP;
                        dsub  <= D_RD;
                    end
                end
                S_DUMP: begin
                    case (dsub)
                        D_RD: begin
                            lat_cnt <= CNT_W'(1);
                            dsub    <= D_WAIT;
                        end
                        D_WAIT: begin
                            if (lat_cnt == CNT_W'(RD_LAT)) begin
                                tx_data_r <= bus.dram_q;
                                dsub      <= D_SEND;
                            end else begin
                                lat_cnt <= lat_cnt + 1'b1;
                            end
                        end
                        D_SEND: begin
                            if (!bus.tx_busy) begin
                                tx_start_r <= 1'b1;
                                dsub       <= D_HOLD1;
                            end
                        end
                        // One blind cycle gives the transmitter time to raise tx_busy.
                        D_HOLD1: dsub <= D_HOLD;
                        D_HOLD: begin
                            if (!bus.tx_busy) begin
                                dump_ptr <= dump_ptr + 1'b1;
                                dsub     <= D_RD;
                                if (dump_ptr == PTR_W'(DUMP_LEN - 1)) begin
                                    phase <= S_DONE;
                                end
                            end
                        end
                        default: dsub <= D_RD;
                    endcase
                end
                S_DONE: ;
                default: phase <= S_LOAD;
            endcase
        end
    end

    always_comb begin
        bus.dram_addr  = addr_r;
        bus.dram_wdata = wdata_r;
        bus.dram_wren  = wren_r;
        case (phase)
            S_RUN: begin
                bus.dram_addr  = bus.proc_addr;
                bus.dram_wdata = bus.proc_wdata;
                bus.dram_wren  = bus.proc_wren;
            end
            S_DUMP: begin
                bus.dram_addr = dump_addr;
                bus.dram_wren = 1'b0;
            end
            S_DONE:  bus.dram_wren = 1'b0;
            default: ;
        endcase
        // Reset kills any write in the very cycle it is asserted.
        if (rst) bus.dram_wren = 1'b0;
    end

    assign bus.enable_processor = (phase == S_RUN) && !rst;
    assign bus.proc_rdata       = bus.dram_q;
    assign bus.tx_start         = tx_start_r;
    assign bus.tx_data          = tx_data_r;
    assign bus.state            = phase;
endmodule

// File: tb/tb_dram_access_controller.sv
// Bench for dram_access_controller: two instances (different dump windows / read latency)
// share stimulus; DRAM and transmitter are modelled here and checked against a reference memory.
module tb_dram_access_controller;
    localparam int LOAD_LEN = 4;
    localparam int BUSY_CYC = 10;
    localparam int A_BASE   = 16'h0010;
    localparam int A_LEN    = 3;
    localparam int B_BASE   = 16'hFFFF;
    localparam int B_LEN    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] proc_addr = 16'h0000;
    logic [7:0]  proc_wdata = 8'h00;
    logic        proc_wren = 1'b0;
    logic        proc_done = 1'b0;

    always #5 clk = ~clk;

    dram_access_controller_if #(.ADDR_W(16), .DATA_W(8)) ia ();
    dram_access_controller_if #(.ADDR_W(16), .DATA_W(8)) ib ();

    dram_access_controller #(
        .ADDR_W(16), .DATA_W(8), .LOAD_LEN(LOAD_LEN),
        .DUMP_BASE(A_BASE), .DUMP_LEN(A_LEN), .RD_LAT(2)
    ) u_dut_a (
        .clk_in(clk),
        .rst(rst),
        .bus(ia)
    );

    dram_access_controller #(
        .ADDR_W(16), .DATA_W(8), .LOAD_LEN(LOAD_LEN),
        .DUMP_BASE(B_BASE), .DUMP_LEN(B_LEN), .RD_LAT(1)
    ) u_dut_b (
        .clk_in(clk),
        .rst(rst),
        .bus(ib)
    );

    assign ia.rx_valid   = rx_valid;
    assign ia.rx_data    = rx_data;
    assign ia.proc_addr  = proc_addr;
    assign ia.proc_wdata = proc_wdata;
    assign ia.proc_wren  = proc_wren;
    assign ia.proc_done  = proc_done;
    assign ib.rx_valid   = rx_valid;
    assign ib.rx_data    = rx_data;
    assign ib.proc_addr  = proc_addr;
    assign ib.proc_wdata = proc_wdata;
    assign ib.proc_wren  = proc_wren;
    assign ib.proc_done  = proc_done;

    // DRAM models: a has two read stages, b has one.
    logic [7:0] mem_a [65536];
    logic [7:0] mem_b [65536];
    logic [7:0] ref_mem [65536];
    logic [7:0] qa1, qa2, qb1;
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) begin
                mem_a[i] = 8'h00;
                mem_b[i] = 8'h00;
            end
            mem_ready = 1'b1;
        end
        qa1 <= mem_a[ia.dram_addr];
        qa2 <= qa1;
        qb1 <= mem_b[ib.dram_addr];
        if (ia.dram_wren) mem_a[ia.dram_addr] = ia.dram_wdata;
        if (ib.dram_wren) mem_b[ib.dram_addr] = ib.dram_wdata;
    end

    assign ia.dram_q = qa2;
    assign ib.dram_q = qb1;

    // Transmitter models: busy for BUSY_CYC cycles after each start, record every byte.
    logic       busy_a, busy_b;
    int         left_a, left_b;
    logic [7:0] hold_a, hold_b;
    logic [7:0] cap_a[$];
    logic [7:0] cap_b[$];
    int         viol_a = 0;
    int         viol_b = 0;
    int         bad_wr = 0;

    always @(posedge clk) begin
        if (rst) begin
            busy_a <= 1'b0;
        end else if (ia.tx_start) begin
            if (busy_a) viol_a++;
            cap_a.push_back(ia.tx_data);
            hold_a <= ia.tx_data;
            busy_a <= 1'b1;
            left_a <= BUSY_CYC;
        end else if (busy_a) begin
            if (ia.tx_data !== hold_a) viol_a++;
            left_a <= left_a - 1;
            if (left_a == 1) busy_a <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            busy_b <= 1'b0;
        end else if (ib.tx_start) begin
            if (busy_b) viol_b++;
            cap_b.push_back(ib.tx_data);
            hold_b <= ib.tx_data;
            busy_b <= 1'b1;
            left_b <= BUSY_CYC;
        end else if (busy_b) begin
            if (ib.tx_data !== hold_b) viol_b++;
            left_b <= left_b - 1;
            if (left_b == 1) busy_b <= 1'b0;
        end
    end

    assign ia.tx_busy = busy_a;
    assign ib.tx_busy = busy_b;

    always @(negedge clk) begin
        if (ia.dram_wren && ia.state[1]) bad_wr++;
        if (ib.dram_wren && ib.state[1]) bad_wr++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 16'h0011;
            1:       return 16'h0012;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic load_bytes(input bit fixed);
        logic [7:0] fixed_bytes [4];
        logic [7:0] b;
        fixed_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < LOAD_LEN; i++) begin
            repeat ($urandom_range(0, 3)) begin
                proc_addr  = 16'($urandom_range(32, 47));
                proc_wdata = 8'($urandom);
                proc_wren  = 1'b1;
                proc_done  = 1'b1;
                @(negedge clk);
            end
            proc_wren = 1'b0;
            proc_done = 1'b0;
            b = fixed ? fixed_bytes[i] : 8'($urandom);
            rx_valid = 1'b1;
            rx_data  = b;
            @(negedge clk);
            rx_valid = 1'b0;
            check_eq("load_wren", 32'(ia.dram_wren), 32'd1);
            check_eq("load_addr", 32'(ia.dram_addr), 32'(i));
            check_eq("load_wdata", 32'(ia.dram_wdata), 32'(b));
            ref_mem[i] = b;
        end
        check_eq("load_last_state", 32'(ia.state), 32'd0);
        @(negedge clk);
        check_eq("run_state_a", 32'(ia.state), 32'd1);
        check_eq("run_state_b", 32'(ib.state), 32'd1);
        check_eq("run_enable", 32'(ia.enable_processor), 32'd1);
    endtask

    task automatic run_phase(input int nwr);
        logic [15:0] a;
        logic [7:0]  d;
        for (int k = 0; k < nwr; k++) begin
            a = pick_addr();
            d = 8'($urandom);
            proc_addr  = a;
            proc_wdata = d;
            proc_wren  = 1'($urandom_range(0, 1));
            rx_valid   = 1'($urandom_range(0, 1));
            rx_data    = 8'($urandom);
            if (proc_wren) ref_mem[a] = d;
            @(negedge clk);
            check_eq("run_enable", 32'(ia.enable_processor), 32'd1);
            check_eq("proc_rdata", 32'(ib.proc_rdata), 32'(qb1));
        end
        rx_valid   = 1'b0;
        proc_addr  = 16'h0010;
        proc_wdata = 8'h55;
        proc_wren  = 1'b1;
        proc_done  = 1'b1;
        ref_mem[16'h0010] = 8'h55;
        @(negedge clk);
        proc_wren = 1'b0;
        proc_done = 1'b0;
        check_eq("dump_state_a", 32'(ia.state), 32'd2);
        check_eq("dump_state_b", 32'(ib.state), 32'd2);
        check_eq("dump_enable_a", 32'(ia.enable_processor), 32'd0);
        check_eq("dump_enable_b", 32'(ib.enable_processor), 32'd0);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!(ia.state == 2'd3 && ib.state == 2'd3) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("done_reached", 32'(cyc < 3000), 32'd1);
    endtask

    task automatic check_dump();
        check_eq("a_tx_count", 32'(cap_a.size()), 32'(A_LEN));
        for (int i = 0; i < A_LEN; i++)
            if (i < cap_a.size())
                check_eq("a_tx_byte", 32'(cap_a[i]), 32'(ref_mem[16'(A_BASE + i)]));
        check_eq("b_tx_count", 32'(cap_b.size()), 32'(B_LEN));
        for (int i = 0; i < B_LEN; i++)
            if (i < cap_b.size())
                check_eq("b_tx_byte", 32'(cap_b[i]), 32'(ref_mem[16'(B_BASE + i)]));
        check_eq("a_tx_protocol", 32'(viol_a), 32'd0);
        check_eq("b_tx_protocol", 32'(viol_b), 32'd0);
    endtask

    task automatic check_done_idle();
        for (int k = 0; k < 6; k++) begin
            rx_valid   = 1'b1;
            rx_data    = 8'($urandom);
            proc_addr  = pick_addr();
            proc_wdata = 8'($urandom);
            proc_wren  = 1'b1;
            proc_done  = 1'b1;
            @(negedge clk);
            check_eq("done_state", 32'(ia.state), 32'd3);
            check_eq("done_tx_start", 32'(ia.tx_start), 32'd0);
            check_eq("done_enable", 32'(ia.enable_processor), 32'd0);
            check_eq("done_wren", 32'(ib.dram_wren), 32'd0);
        end
        rx_valid  = 1'b0;
        proc_wren = 1'b0;
        proc_done = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int na = 0;
        int nb = 0;
        for (int i = 0; i < 65536; i++) begin
            if (mem_a[i] !== ref_mem[i]) na++;
            if (mem_b[i] !== ref_mem[i]) nb++;
        end
        check_eq({tag, "_mem_a_diffs"}, 32'(na), 32'd0);
        check_eq({tag, "_mem_b_diffs"}, 32'(nb), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(ia.state), 32'd0);
        check_eq("rst_enable", 32'(ia.enable_processor), 32'd0);
        check_eq("rst_tx_start", 32'(ia.tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(ia.tx_data), 32'd0);
        check_eq("rst_wren", 32'(ia.dram_wren), 32'd0);
        check_eq("rst_addr", 32'(ia.dram_addr), 32'd0);
        check_eq("rst_wdata", 32'(ia.dram_wdata), 32'd0);
        rst = 1'b0;

        // Pass 1: fixed load bytes, full flow.
        load_bytes(1'b1);
        run_phase(12);
        wait_done();
        check_dump();
        check_done_idle();
        check_mem("p1");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("p2_rst_state", 32'(ia.state), 32'd0);
        cap_a.delete();
        cap_b.delete();

        // Pass 2: abort in the middle of the dump while the transmitter is busy.
        load_bytes(1'b0);
        run_phase(6);
        cyc = 0;
        while (!busy_a && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("abort_busy_seen", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_state_a", 32'(ia.state), 32'd0);
        check_eq("abort_state_b", 32'(ib.state), 32'd0);
        check_eq("abort_tx_start", 32'(ia.tx_start), 32'd0);
        check_eq("abort_addr", 32'(ia.dram_addr), 32'd0);
        check_eq("abort_wren", 32'(ia.dram_wren), 32'd0);
        rst = 1'b0;
        cap_a.delete();
        cap_b.delete();

        // Pass 3: reload after the abort, pointers must restart from zero.
        load_bytes(1'b0);
        run_phase(10);
        wait_done();
        check_dump();
        check_mem("p3");
        check_eq("no_wren_outside_load_run", 32'(bad_wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
